// File: rtl/rarp_rx_deframer.sv
// Reassembles the 7-word RARP stream into parallel ARP/RARP fields and hands one packet
// at a time to the responder over a valid/ready handshake, discarding packets that stall.
//   state     | meaning
//   S_IDLE    | waiting for W0 of a new packet
//   S_COLLECT | W1..W6 being gathered; stall timeout armed
//   S_HOLD    | complete packet presented, upstream held off
module rarp_rx_deframer #(
  parameter logic [7:0] EXP_HLEN    = 8'd6,
  parameter logic [7:0] EXP_PLEN    = 8'd4,
  parameter int         TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_in_word,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic [15:0] o_hdr_type,
  output logic [15:0] o_proto_type,
  output logic [7:0]  o_hdr_addr_length,
  output logic [7:0]  o_pro_addr_length,
  output logic [15:0] o_operation,
  output logic [47:0] o_send_hdr_addr,
  output logic [31:0] o_send_ip_addr,
  output logic [47:0] o_target_hdr_addr,
  output logic [31:0] o_target_ip_addr,
  output logic        o_pkt_valid,
  input  logic        i_pkt_ready,
  output logic        o_pkt_err,
  output logic        o_timeout_pulse,
  output logic [15:0] o_pkt_count
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  localparam logic [15:0] TO_LAST = (TIMEOUT_CYC > 0) ? 16'(TIMEOUT_CYC - 1) : 16'd0;

  state_t      r_state;
  logic [2:0]  r_word_cnt;
  logic [15:0] r_idle_cnt;
  logic        r_pkt_valid;
  logic        r_pkt_err;
  logic        r_timeout_pulse;
  logic [15:0] r_pkt_count;
  logic [15:0] r_htype, r_ptype, r_oper;
  logic [7:0]  r_hlen, r_plen;
  logic [47:0] r_sha, r_tha;
  logic [31:0] r_spa, r_tpa;

  logic w_accept;
  logic w_to_hit;
  logic w_err;

  assign o_in_ready = (r_state != S_HOLD);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_to_hit   = (TIMEOUT_CYC != 0) && (r_idle_cnt == TO_LAST);
  // hlen/plen/oper were stored with W1, so they are settled when W6 arrives
  assign w_err      = ((r_oper != 16'd3) && (r_oper != 16'd4)) ||
                      (r_hlen != EXP_HLEN) || (r_plen != EXP_PLEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_word_cnt      <= 3'd0;
      r_idle_cnt      <= 16'd0;
      r_pkt_valid     <= 1'b0;
      r_pkt_err       <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_pkt_count     <= 16'd0;
    end else begin
      r_timeout_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idle_cnt <= 16'd0;
          if (w_accept) begin
            r_word_cnt <= 3'd1;
            r_state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_idle_cnt <= 16'd0;
            if (r_word_cnt == 3'd6) begin
              r_word_cnt  <= 3'd0;
              r_pkt_valid <= 1'b1;
              r_pkt_err   <= w_err;
              r_state     <= S_HOLD;
            end else begin
              r_word_cnt <= r_word_cnt + 3'd1;
            end
          end else if (w_to_hit) begin
            r_word_cnt      <= 3'd0;
            r_idle_cnt      <= 16'd0;
            r_timeout_pulse <= 1'b1;
            r_state         <= S_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (i_pkt_ready) begin
            r_pkt_valid <= 1'b0;
            r_pkt_count <= r_pkt_count + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_htype <= 16'd0;
      r_ptype <= 16'd0;
      r_hlen  <= 8'd0;
      r_plen  <= 8'd0;
      r_oper  <= 16'd0;
      r_sha   <= 48'd0;
      r_spa   <= 32'd0;
      r_tha   <= 48'd0;
      r_tpa   <= 32'd0;
    end else if (w_accept) begin
      case (r_word_cnt)
        3'd0: {r_htype, r_ptype}             <= i_in_word;
        3'd1: {r_hlen, r_plen, r_oper}       <= i_in_word;
        3'd2: r_sha[47:16]                   <= i_in_word;
        3'd3: {r_sha[15:0], r_spa[31:16]}    <= i_in_word;
        3'd4: {r_spa[15:0], r_tha[47:32]}    <= i_in_word;
        3'd5: r_tha[31:0]                    <= i_in_word;
        3'd6: r_tpa                          <= i_in_word;
        default: ;
      endcase
    end
  end

  assign o_hdr_type        = r_htype;
  assign o_proto_type      = r_ptype;
  assign o_hdr_addr_length = r_hlen;
  assign o_pro_addr_length = r_plen;
  assign o_operation       = r_oper;
  assign o_send_hdr_addr   = r_sha;
  assign o_send_ip_addr    = r_spa;
  assign o_target_hdr_addr = r_tha;
  assign o_target_ip_addr  = r_tpa;
  assign o_pkt_valid       = r_pkt_valid;
  assign o_pkt_err         = r_pkt_err;
  assign o_timeout_pulse   = r_timeout_pulse;
  assign o_pkt_count       = r_pkt_count;

endmodule

// File: tb/tb_rarp_rx_deframer.sv
// Scoreboard bench for rarp_rx_deframer: stimulus pushes expected packets, a negedge
// monitor pops and compares them at each pkt_valid/pkt_ready handshake.
module tb_rarp_rx_deframer;

  typedef struct packed {
    logic [15:0] ht;
    logic [15:0] pt;
    logic [7:0]  hl;
    logic [7:0]  pl;
    logic [15:0] op;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
    logic        err;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_in_word;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] o_hdr_type, o_proto_type, o_operation, o_pkt_count;
  logic [7:0]  o_hdr_addr_length, o_pro_addr_length;
  logic [47:0] o_send_hdr_addr, o_target_hdr_addr;
  logic [31:0] o_send_ip_addr, o_target_ip_addr;
  logic        o_pkt_valid, i_pkt_ready, o_pkt_err, o_timeout_pulse;

  always #5 clk = ~clk;

  rarp_rx_deframer dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_word(i_in_word), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .o_hdr_type(o_hdr_type), .o_proto_type(o_proto_type),
    .o_hdr_addr_length(o_hdr_addr_length), .o_pro_addr_length(o_pro_addr_length),
    .o_operation(o_operation), .o_send_hdr_addr(o_send_hdr_addr),
    .o_send_ip_addr(o_send_ip_addr), .o_target_hdr_addr(o_target_hdr_addr),
    .o_target_ip_addr(o_target_ip_addr), .o_pkt_valid(o_pkt_valid),
    .i_pkt_ready(i_pkt_ready), .o_pkt_err(o_pkt_err),
    .o_timeout_pulse(o_timeout_pulse), .o_pkt_count(o_pkt_count)
  );

  pkt_t dut_view;
  assign dut_view = {o_hdr_type, o_proto_type, o_hdr_addr_length, o_pro_addr_length,
                     o_operation, o_send_hdr_addr, o_send_ip_addr, o_target_hdr_addr,
                     o_target_ip_addr, o_pkt_err};

  int   n_vec = 0;
  int   n_err = 0;
  int   n_to  = 0;
  int   exp_cnt = 0;
  pkt_t sb[$];
  pkt_t mon_p;

  // hand-computed vectors; err column derived by hand from oper/hlen/plen
  localparam pkt_t P1 = '{16'h0001, 16'h0800, 8'd6, 8'd4, 16'd3, 48'hF2AD9325E67B,
                          32'hF55FD57D, 48'hF25992DBF993, 32'hD57AAFF7, 1'b0};
  localparam pkt_t P2 = '{16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, 48'h0011223344AA,
                          32'hC0A80001, 48'h665544332211, 32'hC0A800FE, 1'b1};
  localparam pkt_t P3 = '{16'h0001, 16'h0800, 8'd8, 8'd4, 16'd3, 48'hA1B2C3D4E5F6,
                          32'h0A000001, 48'h0F0E0D0C0B0A, 32'h0A0000FF, 1'b1};
  localparam pkt_t P4 = '{16'h0006, 16'h86DD, 8'd6, 8'd4, 16'd4, 48'h123456789ABC,
                          32'h7F000001, 48'hDEADBEEFCAFE, 32'h08080808, 1'b0};
  localparam pkt_t P5 = '{16'h0001, 16'h0800, 8'd6, 8'd5, 16'd4, 48'hFFFFFFFFFFFF,
                          32'hFFFFFFFF, 48'h000000000001, 32'h00000002, 1'b1};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input pkt_t p, input int i);
    logic [31:0] w;
    case (i)
      0: w = {p.ht, p.pt};
      1: w = {p.hl, p.pl, p.op};
      2: w = p.sha[47:16];
      3: w = {p.sha[15:0], p.spa[31:16]};
      4: w = {p.spa[15:0], p.tha[47:32]};
      5: w = p.tha[31:0];
      default: w = p.tpa;
    endcase
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cnt = 0;
    end else begin
      if (o_timeout_pulse) n_to++;
      if (o_pkt_valid && i_pkt_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pkt", 256'(sb.size()), 256'd1);
        end else begin
          mon_p = sb.pop_front();
          chk("pkt_fields", 256'(dut_view), 256'(mon_p));
          chk("pkt_count_at_hs", 256'(o_pkt_count), 256'(exp_cnt));
          exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        end
      end
    end
  end

  task automatic drive_words(input pkt_t p, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      i_in_valid = 1'b1;
      i_in_word  = word_of(p, i);
      @(posedge clk); #1;
    end
    i_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!(o_in_ready && !o_pkt_valid) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 256'(k < 40), 256'd1);
  endtask

  function automatic logic any_out();
    return |{o_hdr_type, o_proto_type, o_hdr_addr_length, o_pro_addr_length, o_operation,
             o_send_hdr_addr, o_send_ip_addr, o_target_hdr_addr, o_target_ip_addr,
             o_pkt_valid, o_pkt_err, o_timeout_pulse, o_pkt_count};
  endfunction

  pkt_t pl[3] = '{P2, P3, P4};
  int   to_before;

  initial begin
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_word   = 32'd0;
    i_pkt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs_zero", 256'(any_out()), 256'd0);
    chk("rst_in_ready", 256'(o_in_ready), 256'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic packet and one-cycle latency
    sb.push_back(P1);
    drive_words(P1, 0, 6);
    chk("latency_valid", 256'(o_pkt_valid), 256'd1);
    chk("hold_in_ready_low", 256'(o_in_ready), 256'd0);
    @(posedge clk); #1;
    chk("in_ready_after_hs", 256'(o_in_ready), 256'd1);
    chk("count_after_p1", 256'(o_pkt_count), 256'd1);

    // error and non-error opcode/length variants
    for (int i = 0; i < 3; i++) begin
      sb.push_back(pl[i]);
      drive_words(pl[i], 0, 6);
      wait_idle("idle_after_variant");
    end
    chk("count_after_variants", 256'(o_pkt_count), 256'd4);

    // backpressure: hold 10 cycles while junk words are offered
    i_pkt_ready = 1'b0;
    sb.push_back(P5);
    drive_words(P5, 0, 6);
    for (int i = 0; i < 10; i++) begin
      i_in_valid = 1'b1;
      i_in_word  = $urandom;
      @(posedge clk); #1;
      chk("bp_in_ready_low", 256'(o_in_ready), 256'd0);
      chk("bp_fields_stable", 256'(dut_view), 256'(P5));
    end
    i_in_valid  = 1'b0;
    i_pkt_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_return", 256'(o_in_ready), 256'd1);
    chk("bp_count", 256'(o_pkt_count), 256'd5);

    // stall of 16 idle cycles after W3 discards the partial packet
    to_before = n_to;
    drive_words(P2, 0, 3);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k == 15) chk("to_not_early", 256'(o_timeout_pulse), 256'd0);
      if (k == 16) begin
        chk("to_pulse", 256'(o_timeout_pulse), 256'd1);
        chk("to_no_valid", 256'(o_pkt_valid), 256'd0);
      end
      if (k == 17) chk("to_one_cycle", 256'(o_timeout_pulse), 256'd0);
    end
    chk("to_pulse_count", 256'(n_to - to_before), 256'd1);
    chk("to_count_unchanged", 256'(o_pkt_count), 256'd5);
    sb.push_back(P1);
    drive_words(P1, 0, 6);
    wait_idle("idle_after_to");

    // stall of 15 cycles: the next word wins
    to_before = n_to;
    sb.push_back(P3);
    drive_words(P3, 0, 3);
    repeat (15) @(posedge clk);
    #1;
    drive_words(P3, 4, 6);
    wait_idle("idle_after_near_to");
    chk("no_timeout_15", 256'(n_to), 256'(to_before));

    // reset mid-packet
    drive_words(P1, 0, 2);
    rst_n = 1'b0;
    #2;
    chk("midrst_outputs_zero", 256'(any_out()), 256'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_in_ready", 256'(o_in_ready), 256'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back(P4);
    drive_words(P4, 0, 6);
    wait_idle("idle_after_rst");
    chk("count_after_rst", 256'(o_pkt_count), 256'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 256'(sb.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
